mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between an instruction-fetch port and a
// data port. Data accesses win by default. A fetch is forced through after
// STARVE_MAX data grants were made while it waited. A bus access that never
// sees bus_ready is aborted after TIMEOUT cycles. The abort returns zero data
// and sets a sticky error flag.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        stall,
    output logic        err
);

    localparam int unsigned WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUS_D, BUS_I, RESP} state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [31:0]         bus_addr_q, bus_addr_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                dm_ack_q, dm_ack_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         dm_rdata_q, dm_rdata_d;
    logic                err_q, err_d;

    logic in_bus;
    logic timeout_hit;
    logic bus_done;
    logic starve_hit;
    logic grant_d;
    logic grant_i;

    assign in_bus      = (state_q == BUS_D) || (state_q == BUS_I);
    assign timeout_hit = in_bus && !bus_ready && (wait_cnt_q == WAIT_LAST);
    assign bus_done    = in_bus && (bus_ready || timeout_hit);
    // A waiting fetch that has been passed over STARVE_MAX times beats a data request.
    assign starve_hit  = if_req && (starve_cnt_q == STARVE_TOP);
    assign grant_d     = (state_q == IDLE) && (state_d == BUS_D);
    assign grant_i     = (state_q == IDLE) && (state_d == BUS_I);

    // State register: every flop of the block, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so all flops update from pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic: arbitration in IDLE, completion or abort in the BUS states.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dm_req && !starve_hit) begin
                    state_d = BUS_D;
                end else if (if_req) begin
                    state_d = BUS_I;
                end
            end
            BUS_D, BUS_I: begin
                if (bus_done) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and counters.
    always_comb begin
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        bus_req_d    = (state_d == BUS_D) || (state_d == BUS_I);
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        err_d        = err_q;

        if (grant_d) begin
            bus_addr_d  = dm_addr;
            bus_wdata_d = dm_wdata;
            bus_we_d    = dm_we;
            wait_cnt_d  = '0;
            if (if_req && (starve_cnt_q != STARVE_TOP)) begin
                starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            end
        end

        if (grant_i) begin
            bus_addr_d   = if_addr;
            bus_wdata_d  = '0;
            bus_we_d     = 1'b0;
            wait_cnt_d   = '0;
            starve_cnt_d = '0;
        end

        if (in_bus && !bus_ready && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        // Completion or abort: raise the matching ack and capture read data.
        // An abort returns zero data.
        if (bus_done) begin
            bus_we_d = 1'b0;
            if (state_q == BUS_I) begin
                if_ack_d   = 1'b1;
                if_rdata_d = timeout_hit ? 32'h0 : bus_rdata;
            end else begin
                dm_ack_d = 1'b1;
                if (!bus_we_q) begin
                    dm_rdata_d = timeout_hit ? 32'h0 : bus_rdata;
                end
            end
            if (timeout_hit) begin
                err_d = 1'b1;
            end
        end
    end

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign err       = err_q;
    assign stall     = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios driven by two requester processes and a
// memory responder. Expected bus grants and responses are queued when the
// stimulus is issued. Separate monitors pop and compare them when the DUT
// presents a grant or an ack.
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;      // bus_req cycles; 0 = access is aborted, not measured
    } grant_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;    // expected response data
        logic        err;      // expected err at ack time
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        stall;
    logic        err;

    int total;
    int bad;
    int ready_delay;
    bit never_ready;
    bit if_busy;
    bit dm_busy;

    grant_t grant_q[$];
    cmd_t   if_cmd_q[$];
    cmd_t   dm_cmd_q[$];
    resp_t  if_resp_q[$];
    resp_t  dm_resp_q[$];

    mem_arbiter #(.TIMEOUT(16), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .stall     (stall),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by the responder.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h2008_000A;
        return 32'h1000_0000 | a;
    endfunction

    task automatic exp_grant(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int len);
        grant_t g;
        g.we = we; g.addr = addr; g.wdata = wdata; g.len = len;
        grant_q.push_back(g);
    endtask

    task automatic issue_if(input logic [31:0] addr, input logic [31:0] rdata, input logic e);
        cmd_t c;
        c.we = 1'b0; c.addr = addr; c.wdata = '0; c.rdata = rdata; c.err = e;
        if_cmd_q.push_back(c);
    endtask

    task automatic issue_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic e);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata; c.rdata = rdata; c.err = e;
        dm_cmd_q.push_back(c);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((if_busy || dm_busy || if_cmd_q.size() != 0 || dm_cmd_q.size() != 0 ||
                grant_q.size() != 0 || if_resp_q.size() != 0 || dm_resp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completed"}, {31'd0, n < 300}, 32'd1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Memory responder: raises bus_ready after ready_delay wait cycles of an access.
    initial begin : responder
        int   rcnt;
        logic prev;
        bus_ready = 1'b0;
        bus_rdata = 32'hBAD0_BAD0;
        rcnt = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                rcnt      = prev ? rcnt + 1 : 0;
                bus_ready = !never_ready && (rcnt == ready_delay);
                bus_rdata = bus_ready ? mem_rd(bus_addr) : 32'hBAD0_BAD0;
            end else begin
                bus_ready = 1'b0;
                bus_rdata = 32'hBAD0_BAD0;
            end
            prev = bus_req;
        end
    end

    // Fetch requester: holds if_req until its ack, then takes the next command at once.
    initial begin : if_requester
        cmd_t  c;
        resp_t r;
        if_req = 1'b0;
        if_addr = '0;
        if_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if_req = 1'b0;
                if_busy = 1'b0;
            end else begin
                if (if_busy && if_ack) begin
                    if_busy = 1'b0;
                    if_req = 1'b0;
                end
                if (!if_busy && if_cmd_q.size() != 0) begin
                    c = if_cmd_q.pop_front();
                    if_addr = c.addr;
                    if_req = 1'b1;
                    if_busy = 1'b1;
                    r.rdata = c.rdata;
                    r.err = c.err;
                    if_resp_q.push_back(r);
                end
            end
        end
    end

    // Data requester: same handshake as the fetch requester.
    initial begin : dm_requester
        cmd_t  c;
        resp_t r;
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_addr = '0;
        dm_wdata = '0;
        dm_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                dm_req = 1'b0;
                dm_busy = 1'b0;
            end else begin
                if (dm_busy && dm_ack) begin
                    dm_busy = 1'b0;
                    dm_req = 1'b0;
                end
                if (!dm_busy && dm_cmd_q.size() != 0) begin
                    c = dm_cmd_q.pop_front();
                    dm_we = c.we;
                    dm_addr = c.addr;
                    dm_wdata = c.wdata;
                    dm_req = 1'b1;
                    dm_busy = 1'b1;
                    r.rdata = c.rdata;
                    r.err = c.err;
                    dm_resp_q.push_back(r);
                end
            end
        end
    end

    // Bus monitor: each new access must match the next expected grant.
    initial begin : bus_mon
        grant_t cur;
        int     len;
        logic   prev;
        bit     active;
        cur = '0;
        len = 0;
        prev = 1'b0;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req && !prev) begin
                check("grant_queued", {31'd0, grant_q.size() != 0}, 32'd1);
                if (grant_q.size() != 0) begin
                    cur = grant_q.pop_front();
                    active = 1'b1;
                    len = 0;
                end
            end
            if (bus_req && active) begin
                len++;
                check("bus_addr", bus_addr, cur.addr);
                check("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
                if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
            end
            if (!bus_req && prev && active) begin
                if (cur.len != 0) check("bus_len", len, cur.len);
                active = 1'b0;
            end
            prev = bus_req;
        end
    end

    // Ack monitor: each ack pops the requester's expected response.
    initial begin : ack_mon
        resp_t r;
        logic  prev_if;
        logic  prev_dm;
        prev_if = 1'b0;
        prev_dm = 1'b0;
        forever begin
            @(negedge clk);
            if (if_ack || dm_ack) check("single_ack", {31'd0, if_ack & dm_ack}, 32'd0);
            if (if_ack) begin
                check("if_ack_pulse", {31'd0, prev_if}, 32'd0);
                check("if_ack_expected", {31'd0, if_resp_q.size() != 0}, 32'd1);
                if (if_resp_q.size() != 0) begin
                    r = if_resp_q.pop_front();
                    check("if_rdata", if_rdata, r.rdata);
                    check("if_err", {31'd0, err}, {31'd0, r.err});
                end
            end
            if (dm_ack) begin
                check("dm_ack_pulse", {31'd0, prev_dm}, 32'd0);
                check("dm_ack_expected", {31'd0, dm_resp_q.size() != 0}, 32'd1);
                if (dm_resp_q.size() != 0) begin
                    r = dm_resp_q.pop_front();
                    check("dm_rdata", dm_rdata, r.rdata);
                    check("dm_err", {31'd0, err}, {31'd0, r.err});
                end
            end
            prev_if = if_ack;
            prev_dm = dm_ack;
        end
    end

    // Stall monitor: a request is stalled until the cycle its ack is high.
    initial begin : stall_mon
        forever begin
            @(posedge clk);
            #2;
            check("stall", {31'd0, stall},
                  {31'd0, (if_req & ~if_ack) | (dm_req & ~dm_ack)});
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        total = 0;
        bad = 0;
        reset = 1'b1;
        ready_delay = 0;
        never_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_we", {31'd0, bus_we}, 32'd0);
        check("rst_if_ack", {31'd0, if_ack}, 32'd0);
        check("rst_dm_ack", {31'd0, dm_ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single fetch: bus_req in cycle 1, if_ack in cycle 2
        exp_grant(1'b0, 32'h100, 32'h0, 1);
        issue_if(32'h100, 32'h2008_000A, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!if_req && n < 20);
        check("fetch_c0_bus_req", {31'd0, bus_req}, 32'd0);
        check("fetch_c0_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1;
        check("fetch_c1_bus_req", {31'd0, bus_req}, 32'd1);
        check("fetch_c1_if_ack", {31'd0, if_ack}, 32'd0);
        @(negedge clk);
        #1;
        check("fetch_c2_if_ack", {31'd0, if_ack}, 32'd1);
        check("fetch_c2_bus_req", {31'd0, bus_req}, 32'd0);
        check("fetch_c2_if_rdata", if_rdata, 32'h2008_000A);
        wait_idle("fetch");

        // Collision: data wins, then fetch; stall stays high until if_ack
        exp_grant(1'b0, 32'h40, 32'h0, 1);
        exp_grant(1'b0, 32'h100, 32'h0, 1);
        issue_dm(1'b0, 32'h40, 32'h0, 32'h1000_0040, 1'b0);
        issue_if(32'h100, 32'h2008_000A, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!if_req && n < 20);
        n = 0;
        while (!if_ack && n < 20) begin
            check("collision_stall", {31'd0, stall}, 32'd1);
            @(negedge clk);
            #1;
            n++;
        end
        check("collision_if_ack_seen", {31'd0, if_ack}, 32'd1);
        wait_idle("collision");

        // Starvation: four data grants, then the waiting fetch; the counter restarts
        exp_grant(1'b0, 32'h00, 32'h0, 1);
        exp_grant(1'b0, 32'h04, 32'h0, 1);
        exp_grant(1'b0, 32'h08, 32'h0, 1);
        exp_grant(1'b0, 32'h0C, 32'h0, 1);
        exp_grant(1'b0, 32'h104, 32'h0, 1);
        exp_grant(1'b0, 32'h10, 32'h0, 1);
        exp_grant(1'b0, 32'h14, 32'h0, 1);
        exp_grant(1'b0, 32'h108, 32'h0, 1);
        issue_dm(1'b0, 32'h00, 32'h0, 32'h1000_0000, 1'b0);
        issue_dm(1'b0, 32'h04, 32'h0, 32'h1000_0004, 1'b0);
        issue_dm(1'b0, 32'h08, 32'h0, 32'h1000_0008, 1'b0);
        issue_dm(1'b0, 32'h0C, 32'h0, 32'h1000_000C, 1'b0);
        issue_dm(1'b0, 32'h10, 32'h0, 32'h1000_0010, 1'b0);
        issue_dm(1'b0, 32'h14, 32'h0, 32'h1000_0014, 1'b0);
        issue_if(32'h104, 32'h1000_0104, 1'b0);
        issue_if(32'h108, 32'h1000_0108, 1'b0);
        wait_idle("starvation");

        // Store with 3 wait cycles: dm_rdata keeps the last load value
        ready_delay = 3;
        exp_grant(1'b1, 32'h80, 32'hDEAD_BEEF, 4);
        issue_dm(1'b1, 32'h80, 32'hDEAD_BEEF, 32'h1000_0014, 1'b0);
        wait_idle("store");
        check("store_dm_rdata_kept", dm_rdata, 32'h1000_0014);

        // Timeout: 16 bus cycles, zero data, sticky err
        ready_delay = 0;
        never_ready = 1'b1;
        exp_grant(1'b0, 32'h200, 32'h0, 16);
        issue_dm(1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
        wait_idle("timeout");
        never_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("timeout_err_sticky", {31'd0, err}, 32'd1);
            @(negedge clk);
            #1;
        end
        ready_delay = 1;
        exp_grant(1'b0, 32'h44, 32'h0, 2);
        issue_dm(1'b0, 32'h44, 32'h0, 32'h1000_0044, 1'b1);
        wait_idle("after_timeout");

        // Reset during the second BUS_I cycle aborts the fetch with no ack
        ready_delay = 10;
        exp_grant(1'b0, 32'h300, 32'h0, 0);
        issue_if(32'h300, 32'h1000_0300, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus_req && n < 20);
        check("abort_bus_started", {31'd0, bus_req}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort_c2_bus_req", {31'd0, bus_req}, 32'd1);
        check("abort_c2_if_ack", {31'd0, if_ack}, 32'd0);
        @(negedge clk);
        #1;
        check("abort_bus_req", {31'd0, bus_req}, 32'd0);
        check("abort_if_ack", {31'd0, if_ack}, 32'd0);
        check("abort_dm_ack", {31'd0, dm_ack}, 32'd0);
        check("abort_bus_we", {31'd0, bus_we}, 32'd0);
        check("abort_bus_addr", bus_addr, 32'd0);
        check("abort_bus_wdata", bus_wdata, 32'd0);
        check("abort_if_rdata", if_rdata, 32'd0);
        check("abort_dm_rdata", dm_rdata, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        if_resp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);

        // Recovery after reset
        ready_delay = 0;
        exp_grant(1'b0, 32'h104, 32'h0, 1);
        issue_if(32'h104, 32'h1000_0104, 1'b0);
        wait_idle("recovery");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
